// File: rtl/saber_poly_mult_seq_pkg.sv
// Shared types and constants for the Saber negacyclic polynomial multiplier.
// Coefficient widths, secret-digit encoding and scheduler states.
package saber_poly_mult_seq_pkg;

   localparam int COEF_W   = 13;
   localparam int SEC_W    = 4;
   localparam int SIGN_BIT = 3;
   localparam int MAX_MAG  = 5;
   localparam int MAG_W    = $clog2(MAX_MAG + 1);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      MAC,
      DONE
   } state_t;

endpackage

// File: rtl/saber_poly_mult_seq_if.sv
// Operand load, start/status and result read bundle for the multiplier.
// The master drives loads and reads; the slave is the multiplier.
interface saber_poly_mult_seq_if
   import saber_poly_mult_seq_pkg::*;
#(
   parameter int LOGN = 8
) ();

   logic              start;
   logic              a_wr_en;
   logic [LOGN-1:0]   a_wr_addr;
   logic [COEF_W-1:0] a_wr_data;
   logic              s_wr_en;
   logic [LOGN-1:0]   s_wr_addr;
   logic [SEC_W-1:0]  s_wr_data;
   logic [LOGN-1:0]   res_rd_addr;
   logic [COEF_W-1:0] res_rd_data;
   logic              busy;
   logic              done;

   modport master (
      output start, a_wr_en, a_wr_addr, a_wr_data,
      output s_wr_en, s_wr_addr, s_wr_data, res_rd_addr,
      input  res_rd_data, busy, done
   );

   modport slave (
      input  start, a_wr_en, a_wr_addr, a_wr_data,
      input  s_wr_en, s_wr_addr, s_wr_data, res_rd_addr,
      output res_rd_data, busy, done
   );

endinterface

// File: rtl/saber_poly_mult_seq_shifter_mult.sv
// Signed-digit MAC cell: o_ro = i_ri +/- |s|*a, all mod 2^13.
// |s| is built from shifted copies of a; negative zero adds nothing.
module shifter_mult
   import saber_poly_mult_seq_pkg::*;
(
   input  logic [COEF_W-1:0] i_ri,
   input  logic [COEF_W-1:0] i_a,
   input  logic [SEC_W-1:0]  i_s,
   output logic [COEF_W-1:0] o_ro
);

   logic [MAG_W-1:0]  w_mag;
   logic [COEF_W-1:0] w_prod;

   assign w_mag = i_s[MAG_W-1:0];

   // Shift-and-add product of the magnitude and the public coefficient
   always_comb begin
      w_prod = '0;
      for (int b = 0; b < MAG_W; b++) begin
         if (w_mag[b]) w_prod = w_prod + (i_a << b);
      end
   end

   assign o_ro = i_s[SIGN_BIT] ? (i_ri - w_prod) : (i_ri + w_prod);

endmodule

// File: rtl/saber_poly_mult_seq.sv
// Sequential schoolbook multiplier in Z_2^13[x]/(x^N+1).
// Clears the accumulator, then issues one MAC per cycle, j outer, i inner.
module saber_poly_mult_seq
   import saber_poly_mult_seq_pkg::*;
#(
   parameter int N    = 256,
   parameter int LOGN = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   saber_poly_mult_seq_if.slave bus
);

   localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

   logic [COEF_W-1:0] r_a   [N];
   logic [SEC_W-1:0]  r_s   [N];
   logic [COEF_W-1:0] r_acc [N];

   state_t            r_state;
   logic [LOGN-1:0]   r_i;
   logic [LOGN-1:0]   r_j;
   logic              r_busy;
   logic              r_done;
   logic [COEF_W-1:0] r_rd;

   logic [LOGN:0]     w_sum;
   logic [LOGN-1:0]   w_k;
   logic              w_wrap;
   logic [SEC_W-1:0]  w_s_eff;
   logic [COEF_W-1:0] w_mac;

   assign w_sum   = {1'b0, r_i} + {1'b0, r_j};
   assign w_k     = w_sum[LOGN-1:0];
   assign w_wrap  = w_sum[LOGN];
   assign w_s_eff = {r_s[r_j][SIGN_BIT] ^ w_wrap, r_s[r_j][SIGN_BIT-1:0]};

   shifter_mult u_mac (
      .i_ri (r_acc[w_k]),
      .i_a  (r_a[r_i]),
      .i_s  (w_s_eff),
      .o_ro (w_mac)
   );

   // Operand buffers load only while no product is in flight
   always_ff @(posedge clk) begin
      if (!r_busy) begin
         if (bus.a_wr_en) r_a[bus.a_wr_addr] <= bus.a_wr_data;
         if (bus.s_wr_en) r_s[bus.s_wr_addr] <= bus.s_wr_data;
      end
   end

   // Accumulator: zeroed one entry per CLEAR cycle, updated once per MAC
   always_ff @(posedge clk) begin
      if (r_state == CLEAR) begin
         r_acc[r_i] <= '0;
      end else if (r_state == MAC) begin
         r_acc[w_k] <= w_mac;
      end
   end

   // Registered result read port, one cycle of latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rd <= '0;
      else        r_rd <= r_acc[bus.res_rd_addr];
   end

   // Loop scheduler with registered busy/done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_i     <= '0;
         r_j     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_state <= CLEAR;
                  r_busy  <= 1'b1;
                  r_i     <= '0;
                  r_j     <= '0;
               end
            end
            CLEAR: begin
               r_i <= r_i + 1'b1;
               if (r_i == LAST) r_state <= MAC;
            end
            MAC: begin
               r_i <= r_i + 1'b1;
               if (r_i == LAST) begin
                  r_j <= r_j + 1'b1;
                  if (r_j == LAST) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.res_rd_data = r_rd;

endmodule

// File: tb/tb_saber_poly_mult_seq.sv
// Self-checking bench for saber_poly_mult_seq at N=16.
// Table of operand patterns plus control-robustness sequences.
module tb_saber_poly_mult_seq;

   localparam int N    = 16;
   localparam int LOGN = 4;
   localparam int LAT  = N + N * N + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   saber_poly_mult_seq_if #(.LOGN(LOGN)) bus ();

   saber_poly_mult_seq #(.N(N), .LOGN(LOGN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string      name;
      bit         fill;
      int         ai;
      logic [12:0] av;
      int         si;
      logic [3:0] sv;
      int         ei;
      logic [12:0] ev;
   } vec_t;

   vec_t        vt [8];
   logic [12:0] a_ref [N];
   logic [3:0]  s_ref [N];
   logic [12:0] exp_res [N];
   logic [12:0] sb [$];
   int          errs = 0;
   int          checks = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic set_ops(vec_t v);
      for (int x = 0; x < N; x++) begin
         a_ref[x] = (v.fill || x == v.ai) ? v.av : 13'd0;
         s_ref[x] = (v.fill || x == v.si) ? v.sv : 4'd0;
      end
   endtask

   task automatic model();
      logic [12:0] p;
      bit          neg;
      for (int k = 0; k < N; k++) exp_res[k] = 13'd0;
      for (int j = 0; j < N; j++) begin
         for (int i = 0; i < N; i++) begin
            p   = 13'(int'(s_ref[j][2:0]) * int'(a_ref[i]));
            neg = s_ref[j][3] ^ ((i + j) >= N);
            if (neg) exp_res[(i + j) % N] = exp_res[(i + j) % N] - p;
            else     exp_res[(i + j) % N] = exp_res[(i + j) % N] + p;
         end
      end
   endtask

   task automatic load();
      for (int x = 0; x < N; x++) begin
         bus.a_wr_en   = 1'b1;
         bus.a_wr_addr = LOGN'(x);
         bus.a_wr_data = a_ref[x];
         bus.s_wr_en   = 1'b1;
         bus.s_wr_addr = LOGN'(x);
         bus.s_wr_data = s_ref[x];
         @(posedge clk); #1;
      end
      bus.a_wr_en = 1'b0;
      bus.s_wr_en = 1'b0;
   endtask

   task automatic start_pulse();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!bus.done && n < LAT + 50) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run(string name);
      int n;
      start_pulse();
      check({name, " busy after start"}, 32'(bus.busy), 32'd1);
      wait_done(n);
      check({name, " latency"}, 32'(1 + n), 32'(LAT));
      @(posedge clk); #1;
      check({name, " done pulse"}, {bus.done, bus.busy}, 32'd0);
   endtask

   task automatic read_all(string name);
      logic [12:0] e;
      for (int k = 0; k < N; k++) begin
         bus.res_rd_addr = LOGN'(k);
         sb.push_back(exp_res[k]);
         @(posedge clk); #1;
         e = sb.pop_front();
         check($sformatf("%s res[%0d]", name, k), 32'(bus.res_rd_data), 32'(e));
      end
   endtask

   task automatic spot(string name, int idx, logic [12:0] ev);
      bus.res_rd_addr = LOGN'(idx);
      @(posedge clk); #1;
      check($sformatf("%s spot[%0d]", name, idx), 32'(bus.res_rd_data), 32'(ev));
   endtask

   initial begin
      int n;
      vt[0] = '{"identity", 0, 0,  13'd1,    0,  4'b0011, 0,  13'd3};
      vt[1] = '{"wrap",     0, 15, 13'd1,    1,  4'b0001, 0,  13'h1FFF};
      vt[2] = '{"negdigit", 0, 2,  13'd100,  3,  4'b1101, 5,  13'd7692};
      vt[3] = '{"negzero",  0, 4,  13'd77,   2,  4'b1000, 6,  13'd0};
      vt[4] = '{"full0",    1, 0,  13'd8191, 0,  4'b0101, 0,  13'd70};
      vt[5] = '{"full7",    1, 0,  13'd8191, 0,  4'b0101, 7,  13'd0};
      vt[6] = '{"full15",   1, 0,  13'd8191, 0,  4'b0101, 15, 13'd8112};
      vt[7] = '{"wrapneg",  0, 15, 13'd3,    2,  4'b1010, 1,  13'd6};

      bus.start = 1'b1;
      bus.a_wr_en = 1'b0;
      bus.s_wr_en = 1'b0;
      bus.a_wr_addr = '0;
      bus.s_wr_addr = '0;
      bus.a_wr_data = '0;
      bus.s_wr_data = '0;
      bus.res_rd_addr = '0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         bus.start       = 1'($urandom);
         bus.res_rd_addr = LOGN'($urandom);
         bus.a_wr_addr   = LOGN'($urandom);
         bus.a_wr_data   = 13'($urandom);
      end
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset rd", 32'(bus.res_rd_data), 32'd0);
      bus.start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("start in reset", {bus.busy, bus.done}, 32'd0);

      for (int v = 0; v < 8; v++) begin
         set_ops(vt[v]);
         model();
         load();
         run(vt[v].name);
         read_all(vt[v].name);
         spot(vt[v].name, vt[v].ei, vt[v].ev);
      end

      set_ops(vt[2]);
      model();
      load();
      start_pulse();
      repeat (N + 10) begin
         @(posedge clk); #1;
      end
      bus.a_wr_en   = 1'b1;
      bus.a_wr_addr = LOGN'(2);
      bus.a_wr_data = 13'd1234;
      bus.s_wr_en   = 1'b1;
      bus.s_wr_addr = LOGN'(3);
      bus.s_wr_data = 4'b0001;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.a_wr_en = 1'b0;
      bus.s_wr_en = 1'b0;
      bus.start   = 1'b0;
      wait_done(n);
      check("midmac latency", 32'(1 + N + 10 + 1 + n), 32'(LAT));
      read_all("midmac");
      spot("midmac", 5, 13'd7692);

      start_pulse();
      repeat (N + 30) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      set_ops(vt[0]);
      model();
      load();
      run("restart");
      read_all("restart");
      spot("restart", 0, 13'd3);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
